// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer with a prefetch FIFO and a redirect flush.
// The IMEM_FETCH_PERF_EN macro adds fetch and flush performance counters.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_e;

    state_e        state_q, state_d;
    logic          pend_q, pend_d, stale_q, stale_d;
    logic [31:0]   pc_q, pc_d, addr_q, rsp_pc_q, rsp_pc_d, new_pc;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
    logic [AW-1:0] rd_q, wr_q;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   fpc_q  [FIFO_DEPTH];
    logic          gnt, push, pop;

    // A held request keeps its latched address; otherwise the fetch PC is presented.
    assign mem_req_o     = pend_q || (state_q == FETCH &&
                           ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH));
    assign mem_addr_o    = pend_q ? addr_q : pc_q;
    assign gnt           = mem_req_o && mem_gnt_i;
    assign instr_valid_o = cnt_q != '0;
    assign instr_o       = data_q[rd_q];
    assign instr_pc_o    = fpc_q[rd_q];
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign push          = mem_rvalid_i && disc_q == '0 && !redirect_i;
    assign new_pc        = {redirect_pc_i[31:2], 2'b00};

    // Every request still in flight at a redirect belongs to the old stream and is discarded.
    always_comb begin
        out_d    = out_q + CW'(gnt) - CW'(mem_rvalid_i);
        disc_d   = redirect_i ? out_d
                 : disc_q + CW'(gnt && stale_q) - CW'(mem_rvalid_i && disc_q != '0);
        cnt_d    = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        pc_d     = redirect_i ? new_pc : (gnt && !stale_q) ? pc_q + 32'd4 : pc_q;
        rsp_pc_d = redirect_i ? new_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        pend_d   = mem_req_o && !mem_gnt_i;
        stale_d  = pend_d && (stale_q || redirect_i);
        state_d  = disc_d != '0 ? DRAIN : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pend_q   <= 1'b0;
            stale_q  <= 1'b0;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                fpc_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            stale_q  <= stale_d;
            pc_q     <= pc_d;
            addr_q   <= mem_addr_o;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            cnt_q    <= cnt_d;
            if (push) begin
                data_q[wr_q] <= mem_rdata_i;
                fpc_q[wr_q]  <= rsp_pc_q;
            end
            rd_q <= redirect_i ? '0 : rd_q + AW'(pop);
            wr_q <= redirect_i ? '0 : wr_q + AW'(push);
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'(push);
            perf_flush_cnt_o <= perf_flush_cnt_o + 32'(redirect_i);
        end
    end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: vector tables, hand sequences and a randomized memory with a PC-stream model.
module tb_imem_fetch_ctrl;
    localparam int DEPTH = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o, mem_rdata_i = '0;
    logic        instr_valid_o, instr_ready_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] instr_o, instr_pc_o, redirect_pc_i = '0;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o, perf_flush_cnt_o;
`endif

    imem_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
`ifdef IMEM_FETCH_PERF_EN
        , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        gnt, rv;
        logic [31:0] ra;
        logic        rdy, red;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    int checks = 0, failures = 0, n_redir = 0, pops = 0;
    vec_t tab [13];
    logic [31:0] q_a [$];
    int          q_t [$];

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] ra,
                                input logic rdy, input logic red, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_v, input logic [31:0] e_pc);
        return '{gnt: g, rv: rv, ra: ra, rdy: rdy, red: red, rpc: rpc,
                 e_req: e_req, e_addr: e_addr, e_v: e_v, e_pc: e_pc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        chk({tag, ".req"}, 32'(mem_req_o), 32'(v.e_req));
        chk({tag, ".addr"}, mem_addr_o, v.e_addr);
        chk({tag, ".valid"}, 32'(instr_valid_o), 32'(v.e_v));
        if (v.e_v) begin
            chk({tag, ".pc"}, instr_pc_o, v.e_pc);
            chk({tag, ".instr"}, instr_o, f(v.e_pc));
        end
        mem_gnt_i     = v.gnt;
        mem_rvalid_i  = v.rv;
        mem_rdata_i   = v.rv ? f(v.ra) : 32'hDEAD_BEEF;
        instr_ready_i = v.rdy;
        redirect_i    = v.red;
        redirect_pc_i = v.rpc;
        if (v.red) n_redir++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {mem_gnt_i, mem_rvalid_i, instr_ready_i, redirect_i} = '0;
        #1;
        chk("rst.req", 32'(mem_req_o), 32'd0);
        chk("rst.addr", mem_addr_o, 32'h0);
        chk("rst.valid", 32'(instr_valid_o), 32'd0);
        chk("rst.instr", instr_o, 32'h0);
        chk("rst.pc", instr_pc_o, 32'h0);
        q_a.delete();
        q_t.delete();
        n_redir = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        p_req, p_gnt, p_red, red, rdy, rv, g;
        logic [31:0] p_addr, rpc, ra, exp_pc;

        // gnt rv ra rdy red rpc | req addr valid pc
        tab[0]  = mk(0, 0, 0,        0, 0, 0,        0, 32'h0,   0, 0);
        tab[1]  = mk(1, 0, 0,        0, 0, 0,        1, 32'h0,   0, 0);
        tab[2]  = mk(1, 1, 32'h0,    0, 0, 0,        1, 32'h4,   0, 0);
        tab[3]  = mk(0, 1, 32'h4,    0, 0, 0,        0, 32'h8,   1, 32'h0);
        tab[4]  = mk(0, 0, 0,        1, 0, 0,        0, 32'h8,   1, 32'h0);
        tab[5]  = mk(1, 0, 0,        1, 0, 0,        1, 32'h8,   1, 32'h4);
        tab[6]  = mk(0, 1, 32'h8,    1, 0, 0,        1, 32'hC,   0, 0);
        tab[7]  = mk(0, 0, 0,        1, 1, 32'h103,  1, 32'hC,   1, 32'h8);
        tab[8]  = mk(1, 0, 0,        1, 0, 0,        1, 32'hC,   0, 0);
        tab[9]  = mk(0, 1, 32'hC,    1, 0, 0,        0, 32'h100, 0, 0);
        tab[10] = mk(1, 0, 0,        1, 0, 0,        1, 32'h100, 0, 0);
        tab[11] = mk(0, 1, 32'h100,  1, 0, 0,        1, 32'h104, 0, 0);
        tab[12] = mk(0, 0, 0,        0, 0, 0,        1, 32'h104, 1, 32'h100);

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(tab[i], $sformatf("tab%0d", i));

        // Redirect with two outstanding, then wrap from 0xFFFF_FFFC, then redirect at full FIFO.
        do_reset();
        run_vec(mk(0, 0, 0,            0, 0, 0,            0, 32'h0,         0, 0), "seq0");
        run_vec(mk(1, 0, 0,            0, 0, 0,            1, 32'h0,         0, 0), "seq1");
        run_vec(mk(1, 0, 0,            0, 0, 0,            1, 32'h4,         0, 0), "seq2");
        run_vec(mk(0, 0, 0,            0, 1, 32'h103,      0, 32'h8,         0, 0), "seq3");
        run_vec(mk(0, 1, 32'h0,        0, 0, 0,            0, 32'h100,       0, 0), "seq4");
        run_vec(mk(0, 1, 32'h4,        0, 0, 0,            0, 32'h100,       0, 0), "seq5");
        run_vec(mk(1, 0, 0,            0, 0, 0,            1, 32'h100,       0, 0), "seq6");
        run_vec(mk(1, 1, 32'h100,      0, 1, 32'hFFFF_FFFE, 1, 32'h104,      0, 0), "seq7");
        run_vec(mk(0, 1, 32'h104,      0, 0, 0,            0, 32'hFFFF_FFFC, 0, 0), "seq8");
        run_vec(mk(1, 0, 0,            0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0), "seq9");
        run_vec(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0,           1, 32'h0,         0, 0), "seq10");
        run_vec(mk(1, 0, 0,            0, 0, 0,            1, 32'h0,         1, 32'hFFFF_FFFC), "seq11");
        run_vec(mk(0, 1, 32'h0,        0, 0, 0,            0, 32'h4,         1, 32'hFFFF_FFFC), "seq12");
        run_vec(mk(0, 0, 0,            1, 1, 32'h40,       0, 32'h4,         1, 32'hFFFF_FFFC), "seq13");
        run_vec(mk(0, 0, 0,            1, 0, 0,            1, 32'h40,        0, 0), "seq14");
`ifdef IMEM_FETCH_PERF_EN
        chk("perf_flush_seq", perf_flush_cnt_o, 32'd3);
        chk("perf_fetch_seq", perf_fetch_cnt_o, 32'd2);
`endif

        // Randomized memory; delivered PCs must form the stream implied by reset and redirects.
        do_reset();
        exp_pc = 32'h0;
        {p_req, p_gnt, p_red} = '0;
        p_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (p_req && !p_gnt) begin
                chk("req_hold", 32'(mem_req_o), 32'd1);
                chk("addr_hold", mem_addr_o, p_addr);
            end
            chk("credit", (q_a.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
            red = !p_red && ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            rdy = $urandom_range(0, 3) != 0;
            if (instr_valid_o && rdy && !red) begin
                chk("rnd.pc", instr_pc_o, exp_pc);
                chk("rnd.instr", instr_o, f(instr_pc_o));
                exp_pc += 32'd4;
                pops++;
            end
            if (red) exp_pc = rpc & 32'hFFFF_FFFC;
            rv = q_a.size() != 0 && q_t[0] <= cyc && $urandom_range(0, 3) != 0;
            ra = rv ? q_a.pop_front() : 32'h0;
            if (rv) void'(q_t.pop_front());
            g = $urandom_range(0, 2) != 0;
            if (mem_req_o && g) begin
                q_a.push_back(mem_addr_o);
                q_t.push_back(cyc + 1);
            end
            mem_gnt_i     = g;
            mem_rvalid_i  = rv;
            mem_rdata_i   = rv ? f(ra) : $urandom;
            instr_ready_i = rdy;
            redirect_i    = red;
            redirect_pc_i = rpc;
            if (red) n_redir++;
            p_req  = mem_req_o;
            p_gnt  = g;
            p_addr = mem_addr_o;
            p_red  = red;
            @(negedge clk);
        end
        chk("progress", (pops > 500) ? 32'd1 : 32'd0, 32'd1);
`ifdef IMEM_FETCH_PERF_EN
        chk("perf_flush_rnd", perf_flush_cnt_o, n_redir);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
